// File: rtl/mealy_pkg.sv
// +---------------------------------------------------------------------+
// | mealy_pkg                                                            |
// | Shared FSM state encoding and saturating-increment helper.           |
// | Revision: 1.0                                                        |
// +---------------------------------------------------------------------+
`default_nettype none

package mealy_pkg;

   localparam int c_SAT_FN_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic [c_SAT_FN_W-1:0] sat_inc(
      input logic [c_SAT_FN_W-1:0] v,
      input logic [c_SAT_FN_W-1:0] max_v
   );
      if (v >= max_v) return max_v;
      return v + 32'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// +---------------------------------------------------------------------+
// | sat_counter                                                          |
// | Saturating counter with clear / load-one / increment and a max flag. |
// | Revision: 1.0                                                        |
// +---------------------------------------------------------------------+
`default_nettype none

module sat_counter
   import mealy_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_load1,
   input  logic             i_incr,
   output logic [CNT_W-1:0] o_next,
   output logic             o_sat
);

   localparam logic [CNT_W-1:0] c_MAX = '1;

   logic [CNT_W-1:0] r_cnt;

   // Next value is exported so the owner can capture the post-update count
   // in the same edge that the counter itself advances.
   always_comb begin
      o_next = r_cnt;
      if (i_clear) begin
         o_next = '0;
      end else if (i_load1) begin
         o_next = CNT_W'(1);
      end else if (i_incr) begin
         o_next = CNT_W'(sat_inc(32'(r_cnt), 32'(c_MAX)));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= o_next;
      end
   end

   assign o_sat = (r_cnt == c_MAX);

endmodule

`default_nettype wire

// File: rtl/mealy_xor_accum.sv
// +---------------------------------------------------------------------+
// | mealy_xor_accum                                                      |
// | Handshaked Mealy XOR accumulator with free-run and framed modes.     |
// | Revision: 1.0                                                        |
// +---------------------------------------------------------------------+
`default_nettype none

module mealy_xor_accum
   import mealy_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             framed,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic             sof,
   input  logic             eof,
   output logic [WIDTH-1:0] z,
   output logic             z_valid,
   output logic [WIDTH-1:0] res,
   output logic [CNT_W-1:0] res_len,
   output logic             res_ovf,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             restart_err
);

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_next;
   logic [WIDTH-1:0] w_base;
   logic             r_ovf;
   logic             w_ovf_next;
   logic             w_accept;
   logic             w_clear;
   logic             w_load1;
   logic             w_incr;
   logic             w_restart;
   logic             w_done_enter;
   logic [CNT_W-1:0] w_len_next;
   logic             w_len_sat;

   logic [WIDTH-1:0] r_res;
   logic [CNT_W-1:0] r_res_len;
   logic             r_res_ovf;
   logic             r_res_valid;
   logic             r_restart_err;

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_len (
      .clk     (clk),
      .rst     (reset),
      .i_clear (w_clear),
      .i_load1 (w_load1),
      .i_incr  (w_incr),
      .o_next  (w_len_next),
      .o_sat   (w_len_sat)
   );

   // A framed sof in IDLE starts from zero so the first word passes through.
   assign w_base   = (r_state == IDLE && framed && sof) ? '0 : r_q;
   assign z        = w_base ^ x;
   assign in_ready = (r_state != DONE);
   assign w_accept = in_valid & in_ready;
   assign z_valid  = w_accept;

   always_comb begin
      w_state_next = r_state;
      w_q_next     = r_q;
      w_ovf_next   = r_ovf;
      w_clear      = 1'b0;
      w_load1      = 1'b0;
      w_incr       = 1'b0;
      w_restart    = 1'b0;
      w_done_enter = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (!framed) begin
                  w_q_next = r_q ^ x;
               end else if (sof) begin
                  w_q_next     = x;
                  w_load1      = 1'b1;
                  w_ovf_next   = 1'b0;
                  w_done_enter = eof;
                  w_state_next = eof ? DONE : ACCUM;
               end
            end
         end
         ACCUM: begin
            if (w_accept) begin
               if (sof) begin
                  w_q_next   = x;
                  w_load1    = 1'b1;
                  w_ovf_next = 1'b0;
                  w_restart  = 1'b1;
               end else begin
                  w_q_next = r_q ^ x;
                  w_incr   = 1'b1;
                  if (w_len_sat) w_ovf_next = 1'b1;
               end
               if (eof) begin
                  w_done_enter = 1'b1;
                  w_state_next = DONE;
               end
            end
         end
         DONE: begin
            if (res_ready) begin
               w_clear      = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_q           <= '0;
         r_ovf         <= 1'b0;
         r_restart_err <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_q           <= w_q_next;
         r_ovf         <= w_ovf_next;
         r_restart_err <= w_restart;
      end
   end

   // Result captures post-update values so the eof beat is included.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_res       <= '0;
         r_res_len   <= '0;
         r_res_ovf   <= 1'b0;
         r_res_valid <= 1'b0;
      end else if (w_done_enter) begin
         r_res       <= w_q_next;
         r_res_len   <= w_len_next;
         r_res_ovf   <= w_ovf_next;
         r_res_valid <= 1'b1;
      end else if (r_state == DONE && res_ready) begin
         r_res_valid <= 1'b0;
      end
   end

   assign res         = r_res;
   assign res_len     = r_res_len;
   assign res_ovf     = r_res_ovf;
   assign res_valid   = r_res_valid;
   assign restart_err = r_restart_err;

endmodule

`default_nettype wire

// File: tb/tb_mealy_xor_accum.sv
// +---------------------------------------------------------------------+
// | tb_mealy_xor_accum                                                   |
// | Scoreboard bench: default instance plus a CNT_W=2 saturation copy.   |
// | Revision: 1.0                                                        |
// +---------------------------------------------------------------------+
`default_nettype none

module tb_mealy_xor_accum;

   logic       clk = 1'b0;
   logic       reset;
   logic       framed;
   logic       in_valid;
   logic [7:0] x;
   logic       sof;
   logic       eof;
   logic       res_ready;

   logic       in_ready,  s_in_ready;
   logic [7:0] z,         s_z;
   logic       z_valid,   s_z_valid;
   logic [7:0] res,       s_res;
   logic [7:0] res_len;
   logic [1:0] s_res_len;
   logic       res_ovf,   s_res_ovf;
   logic       res_valid, s_res_valid;
   logic       restart_err, s_restart_err;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0]  q_z[$];
   logic [16:0] q_r8[$];
   logic [10:0] q_r2[$];

   always #5 clk = ~clk;

   mealy_xor_accum #(.WIDTH(8), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .framed(framed), .in_valid(in_valid),
      .in_ready(in_ready), .x(x), .sof(sof), .eof(eof), .z(z),
      .z_valid(z_valid), .res(res), .res_len(res_len), .res_ovf(res_ovf),
      .res_valid(res_valid), .res_ready(res_ready), .restart_err(restart_err)
   );

   mealy_xor_accum #(.WIDTH(8), .CNT_W(2)) dut_s (
      .clk(clk), .reset(reset), .framed(framed), .in_valid(in_valid),
      .in_ready(s_in_ready), .x(x), .sof(sof), .eof(eof), .z(s_z),
      .z_valid(s_z_valid), .res(s_res), .res_len(s_res_len), .res_ovf(s_res_ovf),
      .res_valid(s_res_valid), .res_ready(res_ready), .restart_err(s_restart_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got unexpected event want none", nm);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_res(input logic [7:0] r, input logic [7:0] l8, input logic o8,
                          input logic [1:0] l2, input logic o2);
      q_r8.push_back({r, l8, o8});
      q_r2.push_back({r, l2, o2});
   endtask

   task automatic beat(input logic [7:0] xv, input logic s, input logic e,
                       input logic [7:0] ez);
      bit got = 0;
      q_z.push_back(ez);
      x = xv; sof = s; eof = e; in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1;
            break;
         end
      end
      if (!got) fail_now("beat_accept_timeout");
      @(posedge clk);
      #1;
      in_valid = 1'b0; sof = 1'b0; eof = 1'b0; x = 8'h00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; framed = 1'b0; in_valid = 1'b0; x = 8'h00;
      sof = 1'b0; eof = 1'b0; res_ready = 1'b1;
      fork
         begin : monitor
            logic [7:0]  ez;
            logic [16:0] e8;
            logic [10:0] e2;
            forever begin
               @(negedge clk);
               if (!reset) begin
                  if (z_valid) begin
                     if (q_z.size() == 0) fail_now("z_unexpected");
                     else begin
                        ez = q_z.pop_front();
                        chk("z", 32'(z), 32'(ez));
                        chk("z_small", 32'(s_z), 32'(ez));
                     end
                  end
                  if (res_valid && res_ready) begin
                     if (q_r8.size() == 0) fail_now("res_unexpected");
                     else begin
                        e8 = q_r8.pop_front();
                        chk("res", 32'(res), 32'(e8[16:9]));
                        chk("res_len", 32'(res_len), 32'(e8[8:1]));
                        chk("res_ovf", 32'(res_ovf), 32'(e8[0]));
                     end
                  end
                  if (s_res_valid && res_ready) begin
                     if (q_r2.size() == 0) fail_now("res_small_unexpected");
                     else begin
                        e2 = q_r2.pop_front();
                        chk("res_small", 32'(s_res), 32'(e2[10:3]));
                        chk("res_len_small", 32'(s_res_len), 32'(e2[2:1]));
                        chk("res_ovf_small", 32'(s_res_ovf), 32'(e2[0]));
                     end
                  end
               end
            end
         end
         begin : stimulus
            repeat (3) @(posedge clk);
            #1 reset = 1'b0;
            @(negedge clk);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_res_valid", 32'(res_valid), 32'd0);
            chk("rst_restart_err", 32'(restart_err), 32'd0);
            chk("rst_z", 32'(z), 32'd0);
            chk("rst_z_valid", 32'(z_valid), 32'd0);
            step();

            // Free-run
            beat(8'h0F, 1'b0, 1'b0, 8'h0F);
            beat(8'hF0, 1'b0, 1'b0, 8'hFF);
            beat(8'hFF, 1'b0, 1'b0, 8'h00);
            @(negedge clk);
            chk("freerun_q_end", 32'(z), 32'd0);
            chk("freerun_no_res", 32'(res_valid), 32'd0);
            step();

            // Framed; first a dropped beat without sof
            framed = 1'b1;
            beat(8'h3C, 1'b0, 1'b0, 8'h3C);
            res_ready = 1'b0;
            exp_res(8'hFE, 8'd3, 1'b0, 2'd3, 1'b0);
            beat(8'hA5, 1'b1, 1'b0, 8'hA5);
            beat(8'h5A, 1'b0, 1'b0, 8'hFF);
            beat(8'h01, 1'b0, 1'b1, 8'hFE);

            // Back-pressure: result held, new beats refused
            for (int i = 0; i < 5; i++) begin
               in_valid = 1'b1; x = 8'h55; sof = 1'b1; eof = 1'b1;
               @(negedge clk);
               chk("bp_in_ready", 32'(in_ready), 32'd0);
               chk("bp_z_valid", 32'(z_valid), 32'd0);
               chk("bp_res_valid", 32'(res_valid), 32'd1);
               chk("bp_res", 32'(res), 32'hFE);
               chk("bp_res_len", 32'(res_len), 32'd3);
               step();
            end
            in_valid = 1'b0; sof = 1'b0; eof = 1'b0; x = 8'h00;
            res_ready = 1'b1;
            step();
            @(negedge clk);
            chk("bp_release_idle", 32'(in_ready), 32'd1);
            chk("bp_release_valid", 32'(res_valid), 32'd0);
            step();

            // Restart mid-frame
            exp_res(8'h77, 8'd2, 1'b0, 2'd2, 1'b0);
            beat(8'h11, 1'b1, 1'b0, 8'h11);
            beat(8'h22, 1'b0, 1'b0, 8'h33);
            @(negedge clk);
            chk("restart_quiet", 32'(restart_err), 32'd0);
            step();
            beat(8'h33, 1'b1, 1'b0, 8'h00);
            @(negedge clk);
            chk("restart_pulse", 32'(restart_err), 32'd1);
            step();
            beat(8'h44, 1'b0, 1'b1, 8'h77);
            @(negedge clk);
            chk("restart_pulse_end", 32'(restart_err), 32'd0);
            step();

            // Saturation frame then a single-beat frame
            exp_res(8'h3F, 8'd6, 1'b0, 2'd3, 1'b1);
            beat(8'h01, 1'b1, 1'b0, 8'h01);
            beat(8'h02, 1'b0, 1'b0, 8'h03);
            beat(8'h04, 1'b0, 1'b0, 8'h07);
            beat(8'h08, 1'b0, 1'b0, 8'h0F);
            beat(8'h10, 1'b0, 1'b0, 8'h1F);
            beat(8'h20, 1'b0, 1'b1, 8'h3F);
            exp_res(8'h5C, 8'd1, 1'b0, 2'd1, 1'b0);
            beat(8'h5C, 1'b1, 1'b1, 8'h5C);
            step();

            // Reset mid-frame abandons the frame
            beat(8'h12, 1'b1, 1'b0, 8'h12);
            beat(8'h34, 1'b0, 1'b0, 8'h26);
            reset = 1'b1;
            step();
            reset = 1'b0;
            @(negedge clk);
            chk("midrst_res_valid", 32'(res_valid), 32'd0);
            chk("midrst_in_ready", 32'(in_ready), 32'd1);
            chk("midrst_q", 32'(z), 32'd0);
            step();
            exp_res(8'h9A, 8'd1, 1'b0, 2'd1, 1'b0);
            beat(8'h9A, 1'b1, 1'b1, 8'h9A);
            repeat (3) step();

            chk("z_queue_drained", 32'(q_z.size()), 32'd0);
            chk("res_queue_drained", 32'(q_r8.size()), 32'd0);
            chk("res_small_queue_drained", 32'(q_r2.size()), 32'd0);
         end
      join_any
      disable fork;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
